// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared FSM state encoding and default widths for the pixel fetch path
package vga_pkg;

    typedef logic [0:0] fsm_state_t;

    localparam fsm_state_t IDLE = 1'b0;
    localparam fsm_state_t RUN  = 1'b1;

    localparam int RAM_WIDTH_DEF   = 18;
    localparam int PIXEL_WIDTH_DEF = 6;
    localparam int FIFO_DEPTH_DEF  = 4;

endpackage

// File: rtl/pixel_fetch_if.sv
// rtl/pixel_fetch_if.sv - display-side and BRAM-side signals of pixel_fetch
//
// master: the pixel_fetch view (drives pixel/BRAM request signals).
// slave : the environment view (display timing + BRAM model).
//   frame_start_i  restart pulse           pixel_req_i    display consumes a pixel
//   pixel_o        current pixel           pixel_valid_o  pixel_o is valid
//   underflow_o    sticky starvation flag
//   addra_o/ena_o/wea_o  BRAM read port    douta_i        BRAM data, one cycle after ena_o
interface pixel_fetch_if
    import vga_pkg::*;
#(
    parameter int RAM_WIDTH   = RAM_WIDTH_DEF,
    parameter int ADDR_WIDTH  = 10,
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF
);

    logic                   frame_start_i;
    logic                   pixel_req_i;
    logic [PIXEL_WIDTH-1:0] pixel_o;
    logic                   pixel_valid_o;
    logic                   underflow_o;
    logic [ADDR_WIDTH-1:0]  addra_o;
    logic                   ena_o;
    logic                   wea_o;
    logic [RAM_WIDTH-1:0]   douta_i;

    modport master (
        input  frame_start_i, pixel_req_i, douta_i,
        output pixel_o, pixel_valid_o, underflow_o, addra_o, ena_o, wea_o
    );

    modport slave (
        output frame_start_i, pixel_req_i, douta_i,
        input  pixel_o, pixel_valid_o, underflow_o, addra_o, ena_o, wea_o
    );

endinterface

// File: rtl/pixel_fetch_fifo.sv
// rtl/pixel_fetch_fifo.sv - first-word-fall-through prefetch FIFO with occupancy count
//
// Ports: clka/rstna clock and sync active-low reset; flush empties the FIFO;
// push/push_data write one word; pop drops the head; head is the oldest word
// (valid whenever count != 0); count is the number of stored words.
module pixel_fetch_fifo
    import vga_pkg::*;
#(
    parameter int WIDTH = RAM_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                       clka,
    input  logic                       rstna,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clka) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clka) begin
        if (!rstna || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/pixel_fetch.sv
// rtl/pixel_fetch.sv - prefetches frame-buffer words from BRAM and unpacks them into pixels
//
// Ports: clka clock; rstna sync active-low reset; bus (pixel_fetch_if.master)
// carries the display handshake (frame_start_i, pixel_req_i, pixel_o,
// pixel_valid_o, underflow_o) and the BRAM read port (addra_o, ena_o, wea_o, douta_i).
module pixel_fetch
    import vga_pkg::*;
#(
    parameter int RAM_WIDTH   = RAM_WIDTH_DEF,
    parameter int ADDR_WIDTH  = 10,
    parameter int NUM_WORDS   = 1024,
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic          clka,
    input  logic          rstna,
    pixel_fetch_if.master bus
);

    localparam int PPW   = RAM_WIDTH / PIXEL_WIDTH;
    localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(PPW - 1);

    fsm_state_t            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [IDX_W-1:0]      idx;
    logic                  inflight;
    logic                  underflow;
    logic [CNT_W-1:0]      count;
    logic [RAM_WIDTH-1:0]  head;
    logic                  valid;
    logic                  ena;
    logic                  push;
    logic                  pop;

    assign valid = (count != '0);

    // Reserving a slot for the word still on its way back from BRAM is what
    // makes FIFO overflow impossible.
    assign ena = (state == RUN) && !bus.frame_start_i
              && ((count + CNT_W'(inflight)) < CNT_W'(FIFO_DEPTH));

    // A return that lands on a restart cycle belongs to the old frame.
    assign push = inflight && !bus.frame_start_i;
    assign pop  = bus.pixel_req_i && valid && (idx == LAST_IDX) && !bus.frame_start_i;

    pixel_fetch_fifo #(
        .WIDTH (RAM_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clka      (clka),
        .rstna     (rstna),
        .flush     (bus.frame_start_i),
        .push      (push),
        .push_data (bus.douta_i),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clka) begin
        if (!rstna) begin
            state     <= IDLE;
            addr      <= '0;
            idx       <= '0;
            inflight  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            inflight <= ena;
            if (bus.pixel_req_i && !valid) begin
                underflow <= 1'b1;
            end
            if (bus.frame_start_i) begin
                state <= RUN;
                addr  <= '0;
                idx   <= '0;
            end else begin
                if (ena) begin
                    addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                end
                if (bus.pixel_req_i && valid) begin
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
            end
        end
    end

    assign bus.pixel_o       = valid ? head[idx*PIXEL_WIDTH +: PIXEL_WIDTH] : '0;
    assign bus.pixel_valid_o = valid;
    assign bus.underflow_o   = underflow;
    assign bus.addra_o       = addr;
    assign bus.ena_o         = ena;
    assign bus.wea_o         = 1'b0;

endmodule

// File: tb/tb_pixel_fetch.sv
// tb/tb_pixel_fetch.sv - self-checking bench for pixel_fetch
module tb_pixel_fetch;
    import vga_pkg::*;

    localparam int RW  = 18;
    localparam int AW  = 10;
    localparam int NW  = 8;
    localparam int PW  = 6;
    localparam int FD  = 4;
    localparam int PPW = RW / PW;

    logic clka  = 1'b0;
    logic rstna = 1'b0;
    always #5 clka = ~clka;

    pixel_fetch_if #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW), .PIXEL_WIDTH(PW)) bus ();

    pixel_fetch #(
        .RAM_WIDTH   (RW),
        .ADDR_WIDTH  (AW),
        .NUM_WORDS   (NW),
        .PIXEL_WIDTH (PW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clka  (clka),
        .rstna (rstna),
        .bus   (bus)
    );

    // BRAM model: word i holds pixels 3i+1, 3i+2, 3i+3 (LSB first).
    logic [RW-1:0] mem [NW];
    initial begin
        for (int i = 0; i < NW; i++) begin
            mem[i] = {6'(3*i + 3), 6'(3*i + 2), 6'(3*i + 1)};
        end
        bus.douta_i = '0;
    end
    always @(posedge clka) begin
        if (bus.ena_o) bus.douta_i <= mem[bus.addra_o[2:0]];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int n_reads = 0;
    int model_addr = 0;
    int exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected pixel stream of a fresh frame, several laps long.
    task automatic refill();
        int w;
        int p;
        exp_q.delete();
        for (int k = 0; k < 4 * NW * PPW; k++) begin
            w = (k / PPW) % NW;
            p = k % PPW;
            exp_q.push_back(int'(mem[w][p*PW +: PW]));
        end
    endtask

    task automatic step(input logic fs, input logic req);
        @(posedge clka);
        #1;
        bus.frame_start_i = fs;
        bus.pixel_req_i   = req;
        if (fs) refill();
        @(negedge clka);
    endtask

    // Monitor: read-address model and pixel scoreboard.
    always @(negedge clka) begin
        if (rstna) begin
            chk("wea", int'(bus.wea_o), 0);
            if (bus.ena_o) begin
                chk("addr_seq", int'(bus.addra_o), model_addr);
                model_addr = (model_addr + 1) % NW;
                n_reads++;
            end
            if (bus.frame_start_i) model_addr = 0;
            if (bus.pixel_req_i && bus.pixel_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_pixel: got %0d, expected nothing (queue empty)", bus.pixel_o);
                end else begin
                    chk("sb_pixel", int'(bus.pixel_o), exp_q.pop_front());
                end
            end
        end else begin
            model_addr = 0;
        end
    end

    typedef struct {
        logic fs;
        logic req;
        logic ena;
        int   addr;
        logic valid;
        int   pix;
        logic uf;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;

        // frame start, then idle fill: 4 reads then FIFO full, then consume word 0
        tbl[0] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1, 1'b0, 0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 2, 1'b1, 1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 3, 1'b1, 1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 4, 1'b1, 1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 4, 1'b1, 1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 4, 1'b1, 1, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 4, 1'b1, 2, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 4, 1'b1, 3, 1'b0};

        bus.frame_start_i = 1'b0;
        bus.pixel_req_i   = 1'b0;
        rstna = 1'b0;
        step(0, 0);
        step(0, 0);
        chk("rst_ena",   int'(bus.ena_o), 0);
        chk("rst_valid", int'(bus.pixel_valid_o), 0);
        chk("rst_pixel", int'(bus.pixel_o), 0);
        chk("rst_uf",    int'(bus.underflow_o), 0);
        chk("rst_addr",  int'(bus.addra_o), 0);
        chk("rst_wea",   int'(bus.wea_o), 0);

        @(posedge clka);
        #1;
        rstna   = 1'b1;
        n_reads = 0;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].fs, tbl[i].req);
            chk($sformatf("v%0d_ena", i),   int'(bus.ena_o),         int'(tbl[i].ena));
            chk($sformatf("v%0d_addr", i),  int'(bus.addra_o),       tbl[i].addr);
            chk($sformatf("v%0d_valid", i), int'(bus.pixel_valid_o), int'(tbl[i].valid));
            chk($sformatf("v%0d_pixel", i), int'(bus.pixel_o),       tbl[i].pix);
            chk($sformatf("v%0d_uf", i),    int'(bus.underflow_o),   int'(tbl[i].uf));
        end
        chk("fill_reads", n_reads, 4);

        // Continuous consumption: no gaps, address wraps 6,7,0,1
        for (int i = 0; i < 30; i++) begin
            step(0, 1);
            chk("nogap_valid", int'(bus.pixel_valid_o), 1);
        end
        chk("cont_uf", int'(bus.underflow_o), 0);

        // Restart while the word at addr 5 is in flight
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(0, 1);
            if (bus.ena_o && bus.addra_o == 10'd5) found = 1'b1;
        end
        chk("find_addr5", int'(found), 1);
        step(1, 0);
        step(0, 0);
        chk("flush_valid0", int'(bus.pixel_valid_o), 0);
        step(0, 0);
        chk("flush_valid1", int'(bus.pixel_valid_o), 0);
        step(0, 0);
        chk("restart_valid", int'(bus.pixel_valid_o), 1);
        chk("restart_pixel", int'(bus.pixel_o), int'(mem[0][PW-1:0]));

        // Request one cycle after frame start -> sticky underflow
        step(1, 0);
        step(0, 1);
        step(0, 0);
        chk("uf_set", int'(bus.underflow_o), 1);
        step(1, 0);
        for (int i = 0; i < 5; i++) step(0, 1);
        chk("uf_sticky", int'(bus.underflow_o), 1);

        // One-cycle reset mid-frame
        @(posedge clka);
        #1;
        rstna = 1'b0;
        bus.pixel_req_i = 1'b0;
        exp_q.delete();
        @(posedge clka);
        #1;
        rstna = 1'b1;
        n_reads = 0;
        @(negedge clka);
        chk("mrst_ena",   int'(bus.ena_o), 0);
        chk("mrst_addr",  int'(bus.addra_o), 0);
        chk("mrst_valid", int'(bus.pixel_valid_o), 0);
        chk("mrst_pixel", int'(bus.pixel_o), 0);
        chk("mrst_uf",    int'(bus.underflow_o), 0);
        for (int i = 0; i < 8; i++) step(0, 0);
        chk("mrst_noreads", n_reads, 0);
        chk("mrst_valid_hold", int'(bus.pixel_valid_o), 0);

        // Fresh frame after reset delivers word 0 again
        step(1, 0);
        for (int i = 0; i < 3; i++) step(0, 0);
        chk("post_valid", int'(bus.pixel_valid_o), 1);
        for (int i = 0; i < 6; i++) step(0, 1);
        step(0, 0);
        chk("post_uf", int'(bus.underflow_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
